mouse_cmd_scheduler: RTL
========================

Name: mouse_cmd_scheduler

Overview:
Sequences host-to-mouse PS/2 commands over the shared mouse transmitter/receiver pair. Arbitrates between two command requesters: requester 0 is the power-up config sequencer, requester 1 is the CPU bus register. For each granted request it sends a command byte and an optional argument byte, then waits for the mouse's 0xFA acknowledge after each. Handles resend (0xFE), error (0xFC) and timeout, and holds off the packet decoder while a command is in flight.

Parameters:
TIMEOUT_CYCLES, 5_000_000, cycles allowed per byte for BYTE_SENT and then for ACK (50 ms at 100 MHz)
MAX_RETRY, 3, resend attempts allowed per byte before abort

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
REQ_VALID  in  2  per-requester command request
REQ_CMD  in  2x8  per-requester command byte
REQ_HAS_ARG  in  2  per-requester flag: argument byte follows the command
REQ_ARG  in  2x8  per-requester argument byte
REQ_READY  out  2  one-cycle grant; the request is accepted when VALID and READY are both high
RSP_VALID  out  1  one-cycle completion pulse
RSP_ID  out  1  requester that owns the response
RSP_CODE  out  2  0 OK, 1 TIMEOUT, 2 NACK (0xFC), 3 RETRY_EXHAUSTED
BUSY  out  1  high from grant until RSP_VALID inclusive
STREAM_HOLD  out  1  equals BUSY; packet decoder discards received bytes while high
SEND_BYTE  out  1  one-cycle pulse to the transmitter
BYTE_TO_SEND  out  8  byte to transmit; held stable from the SEND_BYTE pulse until BYTE_SENT
BYTE_SENT  in  1  transmitter-done pulse
BYTE_READY  in  1  receiver byte-valid pulse
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  receiver error; nonzero means parity or framing fault

Behaviour:
- Reset (RESET=0, asynchronous):
  - All outputs 0.
  - State IDLE, RR pointer = 0, retry count = 0, timer = 0.
  - Asserting reset mid-operation immediately deasserts SEND_BYTE and BUSY, drops the request, and emits no response.
- States: IDLE, SEND, WAIT_SENT, WAIT_ACK, RESPOND.
- IDLE:
  - If any REQ_VALID is set, grant one requester: REQ_READY[g] high for 1 cycle.
  - Latch CMD, HAS_ARG and ARG; set phase=CMD; go to SEND.
  - If both requests are valid, the RR pointer selects the winner. The pointer then moves to the other requester.
  - If exactly one is valid, grant it regardless of the pointer and set the pointer to the other requester.
  - Requester 0 wins the first simultaneous request after reset.
- SEND:
  - SEND_BYTE=1 for one cycle.
  - BYTE_TO_SEND = CMD when phase=CMD, ARG when phase=ARG.
  - Clear the timer; go to WAIT_SENT.
  - Latency: grant cycle to SEND_BYTE = 1 cycle.
- WAIT_SENT:
  - On BYTE_SENT, clear the timer and go to WAIT_ACK.
  - If the timer reaches TIMEOUT_CYCLES-1 first, respond with code TIMEOUT.
- WAIT_ACK, acting on each BYTE_READY:
  - Byte = 0xFA with BYTE_ERROR_CODE = 0: if phase=CMD and HAS_ARG, set phase=ARG, reset the retry count and go to SEND. Otherwise respond OK.
  - Byte = 0xFE, or BYTE_ERROR_CODE ≠ 0: if retry count < MAX_RETRY, increment it and go to SEND with the same byte. Otherwise respond RETRY_EXHAUSTED.
  - Byte = 0xFC: respond NACK.
  - Any other byte: ignored; the timer keeps running.
  - Timer expiry: respond TIMEOUT.
- RESPOND:
  - RSP_VALID=1 for one cycle with RSP_ID and RSP_CODE.
  - BUSY stays high this cycle; go to IDLE.
  - REQ_READY is never high in this cycle.
- A BYTE_SENT or BYTE_READY arriving in IDLE is ignored.
- A requester that withdraws REQ_VALID before grant is not served.
- Timer width is ceil(log2(TIMEOUT_CYCLES)) and it saturates; it is cleared on every state entry into WAIT_SENT and WAIT_ACK.
- Retry count is 2 bits (sized for MAX_RETRY); it is cleared at grant and on phase advance.
- Minimum request-to-response time: grant + 1 + transmit time + ACK time + 1 cycles.

Decomposition:
- Package mouse_pkg holds:
  - PS/2 constants: PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ERROR=8'hFC.
  - Command constants: RESET=8'hFF, SET_RATE=8'hF3, SET_RES=8'hE8, EN_REPORT=8'hF4.
  - State enum type.
  - rsp_code_t enum.
- One sub-module, mouse_timeout_timer: loadable clear, saturating count, expiry flag at TIMEOUT_CYCLES-1.

Test Plan:
- Req0 sends 0xF4 with no argument; model returns BYTE_SENT then 0xFA -> exactly one SEND_BYTE with 0xF4; RSP_VALID with ID=0, CODE=0; BUSY returns to 0.
- Req1 sends 0xF3 with argument 0x28; model ACKs both bytes -> SEND_BYTE sequence 0xF3 then 0x28; one RSP with ID=1, CODE=0.
- Both requesters valid in the same cycle, twice in a row -> grants in order 0, 1, 0, 1; responses match grants.
- Model answers 0xFE four times to 0xE8 (TIMEOUT_CYCLES=100 for sim) -> four sends of 0xE8, then RSP CODE=3. With three 0xFE then 0xFA -> CODE=0.
- Model never asserts BYTE_SENT (TIMEOUT_CYCLES=100) -> RSP CODE=1 at cycle 100 after SEND_BYTE. Model answers 0xFC -> CODE=2. Stray byte 0x08 in WAIT_ACK -> ignored.
- RESET pulled low during WAIT_ACK -> all outputs 0 in the same cycle; no RSP_VALID; after release, the next request is granted normally with the RR pointer back at 0.

Source files
------------

// File: rtl/mouse_pkg.sv
// mouse_pkg: PS/2 mouse protocol constants and scheduler types.
package mouse_pkg;
  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR = 8'hFC;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_SET_RES = 8'hE8;
  localparam logic [7:0] CMD_EN_REPORT = 8'hF4;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_SENT, S_WAIT_ACK, S_RESPOND} state_t;
  typedef enum logic [1:0] {RSP_OK, RSP_TIMEOUT, RSP_NACK, RSP_RETRY_EXHAUSTED} rsp_code_t;
endpackage

// File: rtl/mouse_timeout_timer.sv
// mouse_timeout_timer: clearable saturating cycle counter, flags expiry at TIMEOUT_CYCLES-1.
module mouse_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic expired_o
);
  localparam int W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired_o = cnt_q == LAST;
  assign cnt_d = clr_i ? '0 : expired_o ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mouse_cmd_scheduler.sv
// mouse_cmd_scheduler: round-robin arbiter that sends a PS/2 command (+ optional argument)
// to the mouse, waits for each ACK, and retries/aborts on resend, error or timeout.
module mouse_cmd_scheduler
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_valid_i,
  input  logic [1:0][7:0] req_cmd_i,
  input  logic [1:0]      req_has_arg_i,
  input  logic [1:0][7:0] req_arg_i,
  output logic [1:0]      req_ready_o,
  output logic            rsp_valid_o,
  output logic            rsp_id_o,
  output logic [1:0]      rsp_code_o,
  output logic            busy_o,
  output logic            stream_hold_o,
  output logic            send_byte_o,
  output logic [7:0]      byte_to_send_o,
  input  logic            byte_sent_i,
  input  logic            byte_ready_i,
  input  logic [7:0]      byte_read_i,
  input  logic [1:0]      byte_error_code_i
);
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
  state_t state_q, state_d;
  rsp_code_t code_q, code_d;
  logic rr_q, rr_d, owner_q, owner_d, has_arg_q, has_arg_d, phase_q, phase_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d;
  logic [1:0] retry_q, retry_d;
  logic gnt, timer_clr, expired, ack, resend, nack;
  mouse_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(timer_clr), .expired_o(expired)
  );
  assign gnt = &req_valid_i ? rr_q : req_valid_i[1];
  // a receiver fault always means "resend", whatever byte came with it
  assign resend = byte_ready_i && (byte_error_code_i != 2'b00 || byte_read_i == PS2_RESEND);
  assign ack = byte_ready_i && byte_error_code_i == 2'b00 && byte_read_i == PS2_ACK;
  assign nack = byte_ready_i && byte_error_code_i == 2'b00 && byte_read_i == PS2_ERROR;
  assign byte_to_send_o = phase_q ? arg_q : cmd_q;
  assign rsp_id_o = rsp_valid_o & owner_q;
  assign rsp_code_o = rsp_valid_o ? code_q : 2'b00;
  assign busy_o = (state_q != S_IDLE) | (|req_ready_o);
  assign stream_hold_o = busy_o;
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    rr_d = rr_q;
    owner_d = owner_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    has_arg_d = has_arg_q;
    phase_d = phase_q;
    retry_d = retry_q;
    req_ready_o = '0;
    send_byte_o = 1'b0;
    rsp_valid_o = 1'b0;
    timer_clr = 1'b1;
    case (state_q)
      S_IDLE: if (|req_valid_i) begin
        req_ready_o[gnt] = 1'b1;
        owner_d = gnt;
        rr_d = ~gnt;
        cmd_d = req_cmd_i[gnt];
        arg_d = req_arg_i[gnt];
        has_arg_d = req_has_arg_i[gnt];
        phase_d = 1'b0;
        retry_d = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        send_byte_o = 1'b1;
        state_d = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        timer_clr = byte_sent_i;
        if (byte_sent_i) state_d = S_WAIT_ACK;
        else if (expired) begin
          code_d = RSP_TIMEOUT;
          state_d = S_RESPOND;
        end
      end
      S_WAIT_ACK: begin
        timer_clr = 1'b0;
        if (ack && !phase_q && has_arg_q) begin
          phase_d = 1'b1;
          retry_d = '0;
          state_d = S_SEND;
        end else if (ack) begin
          code_d = RSP_OK;
          state_d = S_RESPOND;
        end else if (resend && retry_q < RETRY_LIM) begin
          retry_d = retry_q + 2'd1;
          state_d = S_SEND;
        end else if (resend) begin
          code_d = RSP_RETRY_EXHAUSTED;
          state_d = S_RESPOND;
        end else if (nack) begin
          code_d = RSP_NACK;
          state_d = S_RESPOND;
        end else if (expired) begin
          code_d = RSP_TIMEOUT;
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        rsp_valid_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      code_q <= RSP_OK;
      rr_q <= 1'b0;
      owner_q <= 1'b0;
      cmd_q <= '0;
      arg_q <= '0;
      has_arg_q <= 1'b0;
      phase_q <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      has_arg_q <= has_arg_d;
      phase_q <= phase_d;
      retry_q <= retry_d;
    end
endmodule
